// File: rtl/bytewrite_ram_pkg.sv
// rtl/bytewrite_ram_pkg.sv - shared constants and state type for the byte-write RAM request controller
package bytewrite_ram_pkg;

    localparam int NUM_COL    = 4;
    localparam int COL_WIDTH  = 8;
    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;
    localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/bytewrite_ram_req_ctrl_if.sv
// rtl/bytewrite_ram_req_ctrl_if.sv - request, response and RAM port bundle of the request controller
interface bytewrite_ram_req_ctrl_if #(
    parameter int NUM_COL    = bytewrite_ram_pkg::NUM_COL,
    parameter int COL_WIDTH  = bytewrite_ram_pkg::COL_WIDTH,
    parameter int ADDR_WIDTH = bytewrite_ram_pkg::ADDR_WIDTH
);
    localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rd;
    logic [NUM_COL-1:0]    req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_din;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic                  ram_ena;
    logic [NUM_COL-1:0]    ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  req_valid, req_rd, req_we, req_addr, req_din, rsp_ready, ram_dout,
        output req_ready, rsp_valid, rsp_data, ram_ena, ram_we, ram_addr, ram_din
    );

    modport master (
        output req_valid, req_rd, req_we, req_addr, req_din, rsp_ready, ram_dout,
        input  req_ready, rsp_valid, rsp_data, ram_ena, ram_we, ram_addr, ram_din
    );

endinterface

// File: rtl/bytewrite_rsp_fifo.sv
// rtl/bytewrite_rsp_fifo.sv - in-order read-response FIFO with registered occupancy count
module bytewrite_rsp_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_tvalid,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic [CNT_W-1:0]      count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push;
    logic                  pop;

    assign push       = in_tvalid;
    assign pop        = out_tvalid && out_tready;
    assign out_tvalid = (count != '0);
    assign out_tdata  = out_tvalid ? mem[rd_ptr] : '0;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_tdata;
        end
    end

    // Caller bounds occupancy, so a push never lands on a full FIFO without a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bytewrite_ram_req_ctrl.sv
// rtl/bytewrite_ram_req_ctrl.sv - request-side controller for the byte-write write-first RAM with clear sweep
module bytewrite_ram_req_ctrl #(
    parameter int NUM_COL    = bytewrite_ram_pkg::NUM_COL,
    parameter int COL_WIDTH  = bytewrite_ram_pkg::COL_WIDTH,
    parameter int ADDR_WIDTH = bytewrite_ram_pkg::ADDR_WIDTH,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_start,
    output logic                      init_done,
    bytewrite_ram_req_ctrl_if.slave   bus
);
    import bytewrite_ram_pkg::*;

    localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;
    localparam int CNT_W      = $clog2(RSP_DEPTH + 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  inflight;
    logic [CNT_W-1:0]      occ;
    logic [CNT_W:0]        pending;
    logic                  fire;
    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_data;

    assign pending = {1'b0, occ} + {{CNT_W{1'b0}}, inflight};
    assign fire    = bus.req_valid && bus.req_ready;

    // Ready depends only on registered counts, never on rsp_ready.
    assign bus.req_ready = !rst && (state == RUN) && (pending < (CNT_W + 1)'(RSP_DEPTH));
    assign init_done     = !rst && (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= fire && bus.req_rd;
            clr_addr <= (state == CLEAR) ? clr_addr + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR: if (&clr_addr) state_nxt = RUN;
            RUN: begin
                if (clear_start) state_nxt = (pending == '0) ? CLEAR : DRAIN;
            end
            DRAIN: if (pending == '0) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        bus.ram_ena  = 1'b0;
        bus.ram_we   = '0;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        if (!rst) begin
            case (state)
                CLEAR: begin
                    bus.ram_ena  = 1'b1;
                    bus.ram_we   = {NUM_COL{1'b1}};
                    bus.ram_addr = clr_addr;
                end
                RUN: begin
                    bus.ram_ena  = fire && (bus.req_rd || (|bus.req_we));
                    bus.ram_we   = fire ? bus.req_we : '0;
                    bus.ram_addr = bus.req_addr;
                    bus.ram_din  = bus.req_din;
                end
                default: ;
            endcase
        end
    end

    // RAM read latency is one cycle, so dout is captured while inflight is set.
    bytewrite_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH),
        .CNT_W      (CNT_W)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .in_tvalid  (inflight),
        .in_tdata   (bus.ram_dout),
        .out_tvalid (fifo_valid),
        .out_tready (bus.rsp_ready),
        .out_tdata  (fifo_data),
        .count      (occ)
    );

    assign bus.rsp_valid = fifo_valid;
    assign bus.rsp_data  = fifo_data;

endmodule

// File: tb/tb_bytewrite_ram_req_ctrl.sv
// tb/tb_bytewrite_ram_req_ctrl.sv - directed self-checking bench for bytewrite_ram_req_ctrl
module tb_bytewrite_ram_req_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic clear_start;
    logic init_done;
    int   checks = 0;
    int   errors = 0;

    bytewrite_ram_req_ctrl_if bif ();

    bytewrite_ram_req_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .clear_start (clear_start),
        .init_done   (init_done),
        .bus         (bif)
    );

    always #5 clk = ~clk;

    // Behavioural write-first byte-write RAM, pre-filled with garbage.
    logic [31:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    end

    always @(posedge clk) begin : ram_model
        logic [31:0] w;
        w = mem[bif.ram_addr];
        for (int l = 0; l < 4; l++)
            if (bif.ram_we[l]) w[l*8 +: 8] = bif.ram_din[l*8 +: 8];
        if (bif.ram_ena) begin
            mem[bif.ram_addr] <= w;
            bif.ram_dout      <= w;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at edge+1 on the first sweep cycle; returns at edge+1 of the first RUN cycle.
    task automatic check_sweep(input string tag);
        int bad = 0;
        for (int i = 0; i < 1024; i++) begin
            #1;
            if (!(bif.ram_ena === 1'b1 && bif.ram_we === 4'hF && bif.ram_din === 32'h0 &&
                  bif.ram_addr === 10'(i) && bif.req_ready === 1'b0 && init_done === 1'b0))
                bad++;
            tick();
        end
        check({tag, "_trace_bad"}, bad, 0);
        check({tag, "_init_done"}, init_done, 1'b1);
    endtask

    task automatic send(input logic rd, input logic [3:0] we, input logic [9:0] addr, input logic [31:0] din);
        int n = 0;
        bif.req_valid = 1'b1;
        bif.req_rd    = rd;
        bif.req_we    = we;
        bif.req_addr  = addr;
        bif.req_din   = din;
        #1;
        while (!bif.req_ready && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("send_ready", bif.req_ready, 1'b1);
        check("send_ram_ena", bif.ram_ena, rd || (|we));
        check("send_ram_we", bif.ram_we, we);
        @(posedge clk);
        #1;
        bif.req_valid = 1'b0;
        bif.req_rd    = 1'b0;
        bif.req_we    = '0;
    endtask

    task automatic recv(input logic [31:0] exp, input string tag);
        int n = 0;
        bif.rsp_ready = 1'b1;
        while (!bif.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, bif.rsp_valid, 1'b1);
        check(tag, bif.rsp_data, exp);
        tick();
        bif.rsp_ready = 1'b0;
    endtask

    initial begin
        int accepts;
        int got;
        int n;
        int ena_seen;

        rst           = 1'b1;
        clear_start   = 1'b0;
        bif.req_valid = 1'b0;
        bif.req_rd    = 1'b0;
        bif.req_we    = '0;
        bif.req_addr  = '0;
        bif.req_din   = '0;
        bif.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_init_done", init_done, 1'b0);
        check("rst_req_ready", bif.req_ready, 1'b0);
        check("rst_rsp_valid", bif.rsp_valid, 1'b0);
        check("rst_rsp_data", bif.rsp_data, 32'h0);
        check("rst_ram_ena", bif.ram_ena, 1'b0);
        check("rst_ram_we", bif.ram_we, 4'h0);
        check("rst_ram_addr", bif.ram_addr, 10'h0);
        check("rst_ram_din", bif.ram_din, 32'h0);

        rst = 1'b0;
        check_sweep("sweep_reset");
        check("run_req_ready", bif.req_ready, 1'b1);

        send(1'b0, 4'b1010, 10'd1, 32'hC04040D5);
        send(1'b1, 4'b0000, 10'd1, 32'h0);
        recv(32'hC0004000, "lane_merge_a");
        send(1'b0, 4'b0101, 10'd1, 32'hC04040D5);
        send(1'b1, 4'b0000, 10'd1, 32'h0);
        recv(32'hC04040D5, "lane_merge_b");

        send(1'b0, 4'b1111, 10'd3, 32'h12345678);
        send(1'b0, 4'b0000, 10'd4, 32'hFFFFFFFF);
        tick();
        tick();
        check("write_only_no_rsp", bif.rsp_valid, 1'b0);

        // Write-first combined write+read, response exactly two cycles after accept.
        bif.req_valid = 1'b1;
        bif.req_rd    = 1'b1;
        bif.req_we    = 4'b1010;
        bif.req_addr  = 10'd2;
        bif.req_din   = 32'hC04040D5;
        #1;
        check("wf_ready", bif.req_ready, 1'b1);
        tick();
        bif.req_valid = 1'b0;
        bif.req_rd    = 1'b0;
        bif.req_we    = '0;
        check("wf_valid_n1", bif.rsp_valid, 1'b0);
        tick();
        check("wf_valid_n2", bif.rsp_valid, 1'b1);
        check("wf_data", bif.rsp_data, 32'hC0004000);
        bif.rsp_ready = 1'b1;
        tick();
        bif.rsp_ready = 1'b0;
        check("wf_popped", bif.rsp_valid, 1'b0);

        for (int i = 0; i < 6; i++) send(1'b0, 4'hF, 10'(10 + i), 32'hA5000000 + i);

        // Backpressure: six back-to-back reads against a stalled response side.
        accepts       = 0;
        bif.req_valid = 1'b1;
        bif.req_rd    = 1'b1;
        bif.req_addr  = 10'd10;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bif.req_ready) accepts++;
            tick();
            bif.req_addr = 10'(10 + accepts);
        end
        check("bp_accepts", accepts, 4);
        check("bp_ready_low", bif.req_ready, 1'b0);
        check("bp_head", bif.rsp_data, 32'hA5000000);
        tick();
        check("bp_head_hold", bif.rsp_data, 32'hA5000000);

        bif.rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            #1;
            if (bif.rsp_valid) begin
                check("bp_rsp", bif.rsp_data, 32'hA5000000 + got);
                got++;
            end
            if (bif.req_valid && bif.req_ready) accepts++;
            tick();
            bif.req_addr = 10'(10 + accepts);
            if (accepts >= 6) bif.req_valid = 1'b0;
        end
        check("bp_rsp_count", got, 6);
        check("bp_accept_total", accepts, 6);
        bif.req_valid = 1'b0;
        bif.req_rd    = 1'b0;
        bif.rsp_ready = 1'b0;

        // Clear while three reads are outstanding.
        send(1'b1, 4'h0, 10'd10, 32'h0);
        send(1'b1, 4'h0, 10'd11, 32'h0);
        send(1'b1, 4'h0, 10'd12, 32'h0);
        tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        ena_seen = 0;
        for (int c = 0; c < 5; c++) begin
            clear_start = (c == 2);
            #1;
            if (bif.ram_ena) ena_seen++;
            tick();
        end
        clear_start = 1'b0;
        check("drain_no_sweep", ena_seen, 0);
        check("drain_init_done", init_done, 1'b0);
        check("drain_ready", bif.req_ready, 1'b0);
        bif.rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (bif.ram_ena) break;
            if (bif.rsp_valid) begin
                check("drain_rsp", bif.rsp_data, 32'hA5000000 + got);
                got++;
            end
            tick();
        end
        check("drain_rsp_count", got, 3);
        bif.rsp_ready = 1'b0;
        check_sweep("sweep_drain");
        send(1'b1, 4'h0, 10'd1, 32'h0);
        recv(32'h0, "cleared_addr1");
        send(1'b1, 4'h0, 10'd10, 32'h0);
        recv(32'h0, "cleared_addr10");

        // Reset mid-drain discards the pending response.
        send(1'b1, 4'h0, 10'd5, 32'h0);
        tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        check("rdrain_pending", bif.rsp_valid, 1'b1);
        rst = 1'b1;
        tick();
        check("rdrain_rsp_valid", bif.rsp_valid, 1'b0);
        rst = 1'b0;
        check_sweep("sweep_rst_drain");

        // Reset at sweep address 500 restarts the sweep from zero.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        n = 0;
        while (!(bif.ram_ena && bif.ram_addr == 10'd500) && n < 2000) begin
            tick();
            n++;
        end
        check("rclr_reach_500", bif.ram_addr, 10'd500);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_sweep("sweep_rst_clear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
